// File: rtl/xor_cipher_pkg.sv
// Shared types and constants for the xor_cipher arbiter slice.
// Holds the default byte width, byte type, slot states and index-width helper.
package xor_cipher_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xor_cipher.sv
// Byte-wide XOR cipher datapath shared by all requester channels.
// Ports: data, key in; cipher = data ^ key out (combinational).
module xor_cipher #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] cipher
);

    assign cipher = data ^ key;

endmodule

// File: rtl/xor_cipher_arb.sv
// Round-robin share of one xor_cipher between NUM_CH channels with per-channel
// keys and a single registered output slot (valid/ready).
// Ports: clk, rst_n, key_load/key_ch/key_data (key write),
//        req_valid/req_data/req_ready (per-channel bytes, one-hot grant),
//        rsp_valid/rsp_ready/rsp_data/rsp_ch (result slot).
// Option: define XOR_CIPHER_KEY_ROTATE_EN to rotate a channel key left by one
//         bit after each of its transfers (a same-cycle key_load wins).
module xor_cipher_arb #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = xor_cipher_pkg::DATA_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  key_load,
    input  logic [xor_cipher_pkg::ch_w(NUM_CH)-1:0] key_ch,
    input  logic [DATA_W-1:0]                     key_data,
    input  logic [NUM_CH-1:0]                     req_valid,
    input  logic [NUM_CH*DATA_W-1:0]              req_data,
    output logic [NUM_CH-1:0]                     req_ready,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_W-1:0]                     rsp_data,
    output logic [xor_cipher_pkg::ch_w(NUM_CH)-1:0] rsp_ch
);

    import xor_cipher_pkg::*;

    localparam int CW = ch_w(NUM_CH);

    slot_t             state;
    slot_t             state_nx;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     ptr_nx;
    logic [CW-1:0]     gnt_idx;
    logic [CW-1:0]     scan_idx;
    logic [CW:0]       scan_sum;
    logic              hit;
    logic              free;
    logic              xfer;
    logic [DATA_W-1:0] key [NUM_CH];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_key;
    logic [DATA_W-1:0] cipher;

    assign free = (state == EMPTY) || rsp_ready;

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        hit      = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_sum = {1'b0, rr_ptr} + (CW+1)'(i);
            if (scan_sum >= (CW+1)'(NUM_CH))
                scan_sum = scan_sum - (CW+1)'(NUM_CH);
            scan_idx = scan_sum[CW-1:0];
            if (!hit && req_valid[scan_idx]) begin
                hit     = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && free && hit)
            req_ready[gnt_idx] = 1'b1;
    end

    assign xfer   = |req_ready;
    assign ptr_nx = (gnt_idx == CW'(NUM_CH - 1)) ? '0
                                                 : gnt_idx + CW'(1);

    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_idx == CW'(c)) begin
                sel_data = req_data[c*DATA_W +: DATA_W];
                sel_key  = key[c];
            end
        end
    end

    xor_cipher #(
        .DATA_W (DATA_W)
    ) u_cipher (
        .data   (sel_data),
        .key    (sel_key),
        .cipher (cipher)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                key[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (key_load && key_ch == CW'(c))
                    key[c] <= key_data;
`ifdef XOR_CIPHER_KEY_ROTATE_EN
                else if (xfer && gnt_idx == CW'(c))
                    key[c] <= {key[c][DATA_W-2:0], key[c][DATA_W-1]};
`else
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            rsp_data <= '0;
            rsp_ch   <= '0;
        end else if (xfer) begin
            rr_ptr   <= ptr_nx;
            rsp_data <= cipher;
            rsp_ch   <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (xfer) state_nx = FULL;
            FULL:  if (rsp_ready && !xfer) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid = (state == FULL);
    end

endmodule

// File: tb/tb_xor_cipher_arb.sv
// Scoreboard bench for xor_cipher_arb with NUM_CH=2, DATA_W=8.
// Honours XOR_CIPHER_KEY_ROTATE_EN in its reference model.
module tb_xor_cipher_arb;

    logic       clk;
    logic       rst_n;
    logic       key_load;
    logic [0:0] key_ch;
    logic [7:0] key_data;
    logic [1:0] req_valid;
    logic [15:0] req_data;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [0:0] rsp_ch;

    xor_cipher_arb #(
        .NUM_CH (2),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_ch    (key_ch),
        .key_data  (key_data),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ch    (rsp_ch)
    );

    typedef struct {
        logic [0:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mkey [2];
    int         mptr;
    logic       mfull;
    int         n_vec;
    int         n_bad;
    logic [7:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mkey[0] = 8'h00;
        mkey[1] = 8'h00;
        mptr    = 0;
        mfull   = 1'b0;
    endtask

    // One clock: model step at negedge, then return 1 time unit past posedge.
    task automatic cycle();
        logic       free;
        logic       found;
        int         gi;
        int         j;
        logic [1:0] g;
        exp_t       e;
        @(negedge clk);
        check("valid", rsp_valid, mfull);
        if (mfull && sb.size() > 0) begin
            check("data", rsp_data, sb[0].d);
            check("ch", rsp_ch, sb[0].ch);
        end
        free  = !mfull || rsp_ready;
        found = 1'b0;
        gi    = 0;
        for (int i = 0; i < 2; i++) begin
            j = (mptr + i) % 2;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gi    = j;
            end
        end
        g = 2'b00;
        if (free && found)
            g[gi] = 1'b1;
        check("gnt", req_ready, g);
        if (mfull && rsp_ready && sb.size() > 0)
            void'(sb.pop_front());
        if (g != 2'b00) begin
            e.ch = gi[0:0];
            e.d  = req_data[gi*8 +: 8] ^ mkey[gi];
            sb.push_back(e);
            mptr = (gi + 1) % 2;
        end
        if (key_load)
            mkey[key_ch] = key_data;
`ifdef XOR_CIPHER_KEY_ROTATE_EN
        if (g != 2'b00 && !(key_load && int'(key_ch) == gi))
            mkey[gi] = {mkey[gi][6:0], mkey[gi][7]};
`endif
        if (g != 2'b00)
            mfull = 1'b1;
        else if (rsp_ready)
            mfull = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [7:0] d0,
                           input logic [7:0] d1);
        req_valid = v;
        req_data  = {d1, d0};
    endtask

    task automatic load_key(input logic [0:0] ch, input logic [7:0] k);
        key_load = 1'b1;
        key_ch   = ch;
        key_data = k;
    endtask

    initial begin
        logic [7:0] rot2;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_ch    = '0;
        key_data  = '0;
        rsp_ready = 1'b1;
        set_req(2'b11, 8'h11, 8'h22);
        model_reset();
        #3;
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_ch", rsp_ch, 0);
        check("rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin with both channels valid.
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_valid", rsp_valid, 1);
            check("rr_ch", rsp_ch, i % 2);
        end

        // Backpressure while full.
        rsp_ready = 1'b0;
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold", rsp_data, held);
            check("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_b2b_valid", rsp_valid, 1);
        check("bp_b2b_ch", rsp_ch, 0);
        check("bp_b2b_data", rsp_data, 8'h11);

        // Basic cipher.
        set_req(2'b00, 8'h00, 8'h00);
        cycle();
        load_key(1'b0, 8'hCC);
        cycle();
        key_load = 1'b0;
        set_req(2'b01, 8'hAA, 8'h00);
        cycle();
        set_req(2'b00, 8'h00, 8'h00);
        check("basic_data", rsp_data, 8'h66);
        check("basic_ch", rsp_ch, 0);
        cycle();

        // Key load colliding with a transfer on the same channel.
        set_req(2'b10, 8'h00, 8'hF0);
        load_key(1'b1, 8'h0F);
        cycle();
        key_load = 1'b0;
        check("coll_old", rsp_data, 8'hF0);
        check("coll_ch", rsp_ch, 1);
        cycle();
        check("coll_new", rsp_data, 8'hFF);

        // Key rotation option.
        set_req(2'b00, 8'h00, 8'h00);
        load_key(1'b0, 8'h81);
        cycle();
        key_load = 1'b0;
        set_req(2'b01, 8'h00, 8'h00);
        cycle();
        check("rot_first", rsp_data, 8'h81);
`ifdef XOR_CIPHER_KEY_ROTATE_EN
        rot2 = 8'h03;
`else
        rot2 = 8'h81;
`endif
        cycle();
        check("rot_second", rsp_data, rot2);

        // Reset mid-operation.
        set_req(2'b00, 8'h00, 8'h00);
        rsp_ready = 1'b0;
        cycle();
        check("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", rsp_valid, 0);
        check("async_data", rsp_data, 0);
        check("async_ready", req_ready, 0);
        model_reset();
        #2;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(2'b01, 8'h5A, 8'h00);
        cycle();
        check("post_rst_data", rsp_data, 8'h5A);
        check("post_rst_ch", rsp_ch, 0);
        set_req(2'b00, 8'h00, 8'h00);
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
